// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the parametrised floating-point add/sub core.
//   - state_t          : datapath sequencing states
//   - FLG_*            : bit positions inside the 4-bit flags word
//   - fp_qnan/inf/zero : canonical bit patterns for a given EXP_W/MAN_W.
//                        The result is 64 bits wide; callers slice off the low W bits.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    ADDSUB = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4
  } state_t;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Puts an all-ones exponent field at its position in the word.
  function automatic logic [63:0] fp_exp_ones(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = {64{1'b1}};
    return (~(ones << exp_w)) << man_w;
  endfunction

  // Quiet NaN: sign 0, all-ones exponent, fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return fp_exp_ones(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Signed infinity.
  function automatic logic [63:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    return ({63'd0, sign} << (exp_w + man_w)) | fp_exp_ones(exp_w, man_w);
  endfunction

  // Signed zero.
  function automatic logic [63:0] fp_zero(input logic sign, input int exp_w, input int man_w);
    return {63'd0, sign} << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   i_data  [WIDTH-1:0] : value to scan, MSB first
//   o_count [CW-1:0]    : number of leading zeros (WIDTH when i_data is zero)
module fp_lzc
  import fp_pkg::*;
#(
  parameter int WIDTH = 27,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  // The highest set bit is scanned last, so its count wins.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
      else           o_count = o_count;
    end
  end

endmodule

// File: rtl/fp_addsub_param.sv
// fp_addsub_param: parametrised floating-point adder/subtractor with a fixed
// 4-cycle datapath (IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> IDLE).
// Denormal inputs are flushed to zero. Optional macro FP_ROUND_RNE_EN selects
// round-to-nearest-even. Without it the result is truncated.
//   clock, reset       : rising-edge clock, async active-low reset
//   start, op          : request (taken only when idle), 0 = add, 1 = subtract
//   data_a, data_b [W] : operands, latched on the accepting edge
//   busy, ready        : in-progress flag, one-cycle result strobe
//   data_o [W], flags  : result and {invalid, overflow, underflow, inexact}
// W must not exceed 64.
module fp_addsub_param
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         busy,
  output logic         ready,
  output logic [W-1:0] data_o,
  output logic [3:0]   flags
);

  // The significand layout is {hidden, fraction, guard, round, sticky}.
  localparam int SW  = MAN_W + 4;
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = EXP_W + LZW + 2;  // signed exponent with head-room both ways

  localparam logic [63:0]          QNAN64    = fp_qnan(EXP_W, MAN_W);
  localparam logic [63:0]          INF64     = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [63:0]          ZERO64    = fp_zero(1'b0, EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN      = QNAN64[W-1:0];
  localparam logic [W-1:0]         INF       = INF64[W-1:0];
  localparam logic [W-1:0]         ZERO      = ZERO64[W-1:0];
  localparam logic [XW-1:0]        SHIFT_MAX = XW'(MAN_W + 3);
  localparam logic signed [XW-1:0] EMAX_X    = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE_X     = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X    = XW'(0);

  state_t                 r_state;
  logic [W-1:0]           r_a, r_b;
  logic                   r_sign, r_sub, r_zero, r_special;
  logic signed [XW-1:0]   r_exp;
  logic [SW-1:0]          r_ml, r_ms, r_m;
  logic [SW:0]            r_sum;
  logic [W-1:0]           r_spec_val;
  logic [3:0]             r_spec_flags;

  logic [EXP_W-1:0]       w_ea, w_eb, w_el, w_es;
  logic [MAN_W-1:0]       w_fa, w_fb, w_fl, w_fs;
  logic                   w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_sl, w_special;
  logic [XW-1:0]          w_diff;
  logic [SW-1:0]          w_ml, w_ms0, w_ms, w_norm_m;
  logic [W-1:0]           w_spec_val, w_res;
  logic [3:0]             w_spec_flags, w_res_flags;
  logic [LZW-1:0]         w_lzc;
  logic signed [XW-1:0]   w_norm_e, w_exp_f;
  logic [MAN_W+1:0]       w_rnd;
  logic [MAN_W-1:0]       w_frac;
  logic                   w_inx;

  fp_lzc #(.WIDTH(SW)) u_lzc (
    .i_data  (r_sum[SW-1:0]),
    .o_count (w_lzc)
  );

  // ALIGN: decode, flush denormals, order by magnitude, shift the smaller operand.
  always_comb begin
    w_ea = r_a[W-2:MAN_W];
    w_eb = r_b[W-2:MAN_W];
    w_fa = (w_ea == '0) ? '0 : r_a[MAN_W-1:0];
    w_fb = (w_eb == '0) ? '0 : r_b[MAN_W-1:0];
    w_a_nan = (w_ea == '1) && (w_fa != '0);
    w_b_nan = (w_eb == '1) && (w_fb != '0);
    w_a_inf = (w_ea == '1) && (w_fa == '0);
    w_b_inf = (w_eb == '1) && (w_fb == '0);
    if ({w_ea, w_fa} >= {w_eb, w_fb}) begin
      w_sl = r_a[W-1]; w_el = w_ea; w_fl = w_fa; w_es = w_eb; w_fs = w_fb;
    end else begin
      w_sl = r_b[W-1]; w_el = w_eb; w_fl = w_fb; w_es = w_ea; w_fs = w_fa;
    end
    w_diff = {{(XW-EXP_W){1'b0}}, w_el - w_es};
    w_ml   = {(w_el != '0), w_fl, 3'b000};
    w_ms0  = {(w_es != '0), w_fs, 3'b000};
    // Bits shifted out are OR-ed into the sticky position.
    if (w_diff >= SHIFT_MAX) w_ms = {{(SW-1){1'b0}}, |w_ms0};
    else w_ms = (w_ms0 >> w_diff) | {{(SW-1){1'b0}}, |(w_ms0 & ~({SW{1'b1}} << w_diff))};

    w_special    = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
    w_spec_flags = 4'b0000;
    if (w_a_nan || w_b_nan) begin
      w_spec_val = QNAN;
    end else if (w_a_inf && w_b_inf && (r_a[W-1] != r_b[W-1])) begin
      w_spec_val = QNAN;
      w_spec_flags[FLG_INV] = 1'b1;
    end else if (w_a_inf) begin
      w_spec_val = {r_a[W-1], INF[W-2:0]};
    end else begin
      w_spec_val = {r_b[W-1], INF[W-2:0]};
    end
  end

  // NORM: carry-out shifts right, otherwise left-justify on the leading one.
  always_comb begin
    if (r_sum[SW]) begin
      w_norm_m = {r_sum[SW:2], r_sum[1] | r_sum[0]};
      w_norm_e = r_exp + ONE_X;
    end else begin
      w_norm_m = r_sum[SW-1:0] << w_lzc;
      w_norm_e = r_exp - $signed({{(XW-LZW){1'b0}}, w_lzc});
    end
  end

  // ROUND: round the fraction, then pick zero / underflow / overflow / normal.
  always_comb begin
    w_inx = |r_m[2:0];
`ifdef FP_ROUND_RNE_EN
    w_rnd = {1'b0, r_m[SW-1:3]}
          + {{(MAN_W+1){1'b0}}, r_m[2] & (r_m[1] | r_m[0] | r_m[3])};
`else
    w_rnd = {1'b0, r_m[SW-1:3]};
`endif
    // A round carry yields 10.00..0: fraction is zero, exponent bumps by one.
    if (w_rnd[MAN_W+1]) begin
      w_frac  = w_rnd[MAN_W:1];
      w_exp_f = r_exp + ONE_X;
    end else begin
      w_frac  = w_rnd[MAN_W-1:0];
      w_exp_f = r_exp;
    end
    w_res_flags = 4'b0000;
    if (r_special) begin
      w_res       = r_spec_val;
      w_res_flags = r_spec_flags;
    end else if (r_zero) begin
      w_res = r_sub ? ZERO : {r_sign, ZERO[W-2:0]};
    end else if (w_exp_f <= ZERO_X) begin
      w_res = {r_sign, ZERO[W-2:0]};
      w_res_flags[FLG_UNF] = 1'b1;
      w_res_flags[FLG_INX] = 1'b1;
    end else if (w_exp_f >= EMAX_X) begin
      w_res = {r_sign, INF[W-2:0]};
      w_res_flags[FLG_OVF] = 1'b1;
      w_res_flags[FLG_INX] = 1'b1;
    end else begin
      w_res = {r_sign, w_exp_f[EXP_W-1:0], w_frac};
      w_res_flags[FLG_INX] = w_inx;
    end
  end

  // Sequencer and datapath registers, including the registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      busy <= 1'b0; ready <= 1'b0; data_o <= '0; flags <= 4'b0000;
      r_a <= '0; r_b <= '0; r_sign <= 1'b0; r_sub <= 1'b0; r_zero <= 1'b0;
      r_special <= 1'b0; r_exp <= '0; r_ml <= '0; r_ms <= '0; r_m <= '0;
      r_sum <= '0; r_spec_val <= '0; r_spec_flags <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            r_a     <= data_a;
            r_b     <= {data_b[W-1] ^ op, data_b[W-2:0]};  // subtract = add negated B
            busy    <= 1'b1;
            r_state <= ALIGN;
          end else begin
            busy <= 1'b0;
          end
        end
        ALIGN: begin
          r_sign       <= w_sl;
          r_sub        <= r_a[W-1] ^ r_b[W-1];
          r_exp        <= {{(XW-EXP_W){1'b0}}, w_el};
          r_ml         <= w_ml;
          r_ms         <= w_ms;
          r_special    <= w_special;
          r_spec_val   <= w_spec_val;
          r_spec_flags <= w_spec_flags;
          r_state      <= ADDSUB;
        end
        ADDSUB: begin
          // Operands are ordered, so the difference never goes negative.
          r_sum   <= r_sub ? ({1'b0, r_ml} - {1'b0, r_ms}) : ({1'b0, r_ml} + {1'b0, r_ms});
          r_state <= NORM;
        end
        NORM: begin
          r_m     <= w_norm_m;
          r_exp   <= w_norm_e;
          r_zero  <= (r_sum == '0);
          r_state <= ROUND;
        end
        ROUND: begin
          data_o  <= w_res;
          flags   <= w_res_flags;
          ready   <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          ready   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_param.sv
// Self-checking bench for fp_addsub_param: single- and half-precision instances,
// table of directed vectors plus handshake and reset sequences.
module tb_fp_addsub_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s_start, s_op, s_busy, s_ready;
  logic [31:0] s_a, s_b, s_do;
  logic [3:0]  s_fl;
  logic        h_start, h_op, h_busy, h_ready;
  logic [15:0] h_a, h_b, h_do;
  logic [3:0]  h_fl;

  fp_addsub_param #(.EXP_W(8), .MAN_W(23)) u_sp (
    .clock(clk), .reset(reset), .start(s_start), .op(s_op),
    .data_a(s_a), .data_b(s_b), .busy(s_busy), .ready(s_ready),
    .data_o(s_do), .flags(s_fl)
  );

  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clock(clk), .reset(reset), .start(h_start), .op(h_op),
    .data_a(h_a), .data_b(h_b), .busy(h_busy), .ready(h_ready),
    .data_o(h_do), .flags(h_fl)
  );

  logic        sel_h = 1'b0;
  logic        cur_busy, cur_ready;
  logic [31:0] cur_do;
  logic [3:0]  cur_fl;
  assign cur_busy  = sel_h ? h_busy  : s_busy;
  assign cur_ready = sel_h ? h_ready : s_ready;
  assign cur_do    = sel_h ? {16'h0000, h_do} : s_do;
  assign cur_fl    = sel_h ? h_fl : s_fl;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp_d;
    logic [3:0]  exp_f;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction with full handshake timing checks.
  task automatic run_op(input logic h, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input string name,
                        output logic [31:0] d, output logic [3:0] f);
    int n;
    int nb;
    logic got;
    @(negedge clk);
    sel_h = h;
    if (h) begin
      h_a = a[15:0]; h_b = b[15:0]; h_op = op; h_start = 1'b1;
    end else begin
      s_a = a; s_b = b; s_op = op; s_start = 1'b1;
    end
    @(negedge clk);
    h_start = 1'b0;
    s_start = 1'b0;
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 20) begin
      if (cur_ready) got = 1'b1;
      else begin
        if (cur_busy) nb++;
        @(negedge clk);
        n++;
      end
    end
    check({name, " ready_seen"}, {31'd0, got}, 32'd1);
    check({name, " latency"}, n, 32'd4);
    check({name, " busy_cycles"}, nb, 32'd4);
    check({name, " busy_at_ready"}, {31'd0, cur_busy}, 32'd0);
    d = cur_do;
    f = cur_fl;
    @(negedge clk);
    check({name, " ready_one_cycle"}, {31'd0, cur_ready}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  f;
    int rc;
    logic [31:0] tie_d;

`ifdef FP_ROUND_RNE_EN
    tie_d = 32'h3F80_0002;
`else
    tie_d = 32'h3F80_0001;
`endif
    vecs[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000};
    vecs[1]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0000};
    vecs[2]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b0101};
    vecs[3]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b1000};
    vecs[4]  = '{32'h3F80_0001, 32'h3380_0000, 1'b0, tie_d,         4'b0001};
    vecs[5]  = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 4'b0000};
    vecs[6]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b0000};
    vecs[7]  = '{32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 4'b0000};
    vecs[8]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 4'b0000};
    vecs[9]  = '{32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 4'b0001};
    vecs[10] = '{32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000, 4'b0011};
    vecs[11] = '{32'hC000_0000, 32'h3F80_0000, 1'b1, 32'hC040_0000, 4'b0000};
    vecs[12] = '{32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, 4'b0000};
    vecs[13] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 4'b0000};
    vecs[14] = '{32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0001};

    reset = 1'b0;
    s_start = 1'b0; s_op = 1'b0; s_a = 32'h0; s_b = 32'h0;
    h_start = 1'b0; h_op = 1'b0; h_a = 16'h0; h_b = 16'h0;
    #12;
    check("reset busy", {31'd0, s_busy}, 32'd0);
    check("reset ready", {31'd0, s_ready}, 32'd0);
    check("reset data_o", s_do, 32'h0);
    check("reset flags", {28'd0, s_fl}, 32'd0);
    check("reset half data_o", {16'd0, h_do}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].op, $sformatf("v%0d", i), d, f);
      check($sformatf("v%0d data_o", i), d, vecs[i].exp_d);
      check($sformatf("v%0d flags", i), {28'd0, f}, {28'd0, vecs[i].exp_f});
    end

    // Half precision.
    run_op(1'b1, 32'h3C00, 32'h3C00, 1'b0, "h_one_plus_one", d, f);
    check("h_one_plus_one data_o", d, 32'h4000);
    check("h_one_plus_one flags", {28'd0, f}, 32'd0);
    run_op(1'b1, 32'h0001, 32'h0000, 1'b0, "h_denorm", d, f);
    check("h_denorm data_o", d, 32'h0000);
    check("h_denorm flags", {28'd0, f}, 32'd0);
    sel_h = 1'b0;

    // Start held during busy is ignored: exactly one ready, first operands used.
    @(negedge clk);
    s_a = 32'h3F80_0000; s_b = 32'h4000_0000; s_op = 1'b0; s_start = 1'b1;
    rc = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) begin s_a = 32'h7F7F_FFFF; s_b = 32'h7F7F_FFFF; end
      if (c == 2) s_start = 1'b0;
      if (s_ready) rc++;
    end
    check("busy_start ready_count", rc, 32'd1);
    check("busy_start data_o", s_do, 32'h4040_0000);

    // Start held across the ready cycle launches a second operation.
    @(negedge clk);
    s_a = 32'h3F80_0000; s_b = 32'h3F80_0000; s_op = 1'b0; s_start = 1'b1;
    rc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 5) s_start = 1'b0;
      if (s_ready) rc++;
    end
    check("held_start ready_count", rc, 32'd2);
    check("held_start data_o", s_do, 32'h4000_0000);

    // Reset during ADDSUB abandons the operation.
    @(negedge clk);
    s_a = 32'h3F80_0000; s_b = 32'h4000_0000; s_op = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    check("midreset busy_before", {31'd0, s_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("midreset busy", {31'd0, s_busy}, 32'd0);
    check("midreset ready", {31'd0, s_ready}, 32'd0);
    check("midreset data_o", s_do, 32'h0);
    check("midreset flags", {28'd0, s_fl}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s_ready) rc++;
    end
    check("midreset no_ready", rc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_param.md
Name: fp_addsub_param

Overview:
Parametrised IEEE-754-style floating-point adder/subtractor. It succeeds the fixed single-precision add/sub core.
- Generalised to any exponent/mantissa width.
- Fixed-latency FSM datapath with guard/round/sticky bits and exception flags.
- Sits behind the same start/busy/ready handshake, so it drops into the existing top level and benches.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored fraction width, hidden bit excluded (>=2)
W, 1+EXP_W+MAN_W, derived total word width; not overridden by users

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request; sampled only when busy=0
op     in  1  0 = data_a + data_b, 1 = data_a - data_b
data_a in  W  operand A, sampled on the accepting edge
data_b in  W  operand B, sampled on the accepting edge
busy   out 1  operation in progress
ready  out 1  one-cycle pulse: data_o/flags are new
data_o out W  result, held until the next result
flags  out 4  {invalid, overflow, underflow, inexact}, held with data_o

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, ready=0, data_o=0, flags=0. An operation in flight is abandoned and produces no ready.
- States: IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> IDLE. Fixed path, no early exit.
- IDLE accepts when start=1 on edge k:
  - latch operands and op; apply op by inverting the sign of B;
  - busy=1 from after edge k until the edge that returns to IDLE.
- Latency: ROUND->IDLE happens on edge k+4. At that edge data_o and flags are registered, ready=1 and busy=0 for exactly one cycle.
- start while busy=1 is ignored, not queued. start held high in IDLE across the ready cycle starts a new operation on the next edge.
- ALIGN:
  - swap operands so |A|>=|B| (compare exponent, then fraction);
  - right-shift B's significand by the exponent difference;
  - keep guard, round and sticky bits;
  - a shift >= MAN_W+3 collapses B to sticky only.
- ADDSUB: add or subtract significands (MAN_W+4 bits plus carry). The result sign is the sign of the larger operand.
- NORM:
  - on carry-out, shift right 1 and increment the exponent, folding the lost bit into sticky;
  - otherwise shift left by the leading-zero count (fp_lzc) and decrement the exponent.
- ROUND: round per the Optional Feature. A round carry renormalises. inexact = G|R|S before rounding.
- Denormals: flushed to zero on input (exp=0 is treated as signed zero). A result with exponent <= 0 yields signed zero with underflow=1 and inexact=1.
- Exact cancellation yields +0.
- Specials: exponent all-ones is Inf/NaN.
  - Any NaN input gives canonical qNaN {0, all-ones exp, 1 followed by zeros}.
  - Inf - Inf (effective) gives qNaN with invalid=1.
  - Otherwise Inf propagates with the correct sign.
  - Specials still take the full 4-cycle latency.
- Overflow (exponent >= 2^EXP_W-1 after rounding) gives signed Inf with overflow=1 and inexact=1.

Optional Feature:
Macro FP_ROUND_RNE_EN.
- Defined: round-to-nearest-even. Increment when G & (R | S | LSB).
- Undefined: truncation (round toward zero). G/R/S only set inexact. The rounding incrementer is removed from the netlist.
- Latency is identical in both builds.

Decomposition:
- Package fp_pkg holds:
  - state enum (IDLE, ALIGN, ADDSUB, NORM, ROUND);
  - flag bit-index constants FLG_INV, FLG_OVF, FLG_UNF, FLG_INX;
  - functions that build canonical qNaN/Inf/zero patterns from EXP_W/MAN_W.
- One sub-module: fp_lzc, a parametrised combinational leading-zero counter (input width MAN_W+4) used by NORM.

Test Plan:
1. Default widths: data_a=3F800000, data_b=40000000, op=0, start pulsed one cycle.
   -> busy=1 for 4 cycles, then ready pulse; data_o=40400000, flags=0.
2. data_a=3F800000, data_b=3F800000, op=1.
   -> data_o=00000000 (+0), flags=0.
3. Overflow: data_a=7F7FFFFF, data_b=7F7FFFFF, op=0.
   -> data_o=7F800000, flags=0101.
   Then data_a=7F800000, data_b=7F800000, op=1.
   -> data_o=7FC00000, flags=1000.
4. Rounding tie: data_a=3F800001, data_b=33800000, op=0.
   -> with FP_ROUND_RNE_EN: data_o=3F800002, flags=0001.
   -> without it: data_o=3F800001, flags=0001.
5. Half precision (EXP_W=5, MAN_W=10): data_a=3C00, data_b=3C00, op=0.
   -> data_o=4000.
   Also data_a=0001 (denormal) + 0000.
   -> data_o=0000.
6. Handshake and reset:
   - a second start during busy is ignored; exactly one ready per accepted start;
   - reset=0 asserted mid-ADDSUB -> busy=0, ready=0, data_o=0 immediately, with no ready after reset is released.
